// File: rtl/eth_pong_responder.sv
// Ping/pong turnaround engine: captures an accepted ping, waits a holdoff,
// requests a pong transmission and tracks the outcome in statistics counters.
module eth_pong_responder #(
    parameter logic [15:0] MIN_PSIZE = 16'd46
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable_i,
    input  logic [31:0] holdoff_time_i,
    input  logic [31:0] tx_timeout_i,
    input  logic        rx_ping_valid_i,
    input  logic [63:0] rx_ping_id_i,
    input  logic [15:0] rx_psize_i,
    output logic        tx_trigger_o,
    input  logic        tx_begin_i,
    output logic [63:0] tx_ping_id_o,
    output logic [15:0] tx_psize_o,
    output logic        done_o,
    output logic [63:0] pongs_sent_o,
    output logic [63:0] pings_dropped_o,
    output logic [63:0] tx_timeouts_o,
    output logic [63:0] out_of_order_o
);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StHoldoff = 2'd1,
        StWaitTx  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] count_q, count_d;
    logic        trigger_q, trigger_d;
    logic        done_q, done_d;
    logic [63:0] ping_id_q, ping_id_d;
    logic [15:0] psize_q, psize_d;
    logic [63:0] expected_id_q, expected_id_d;
    logic        seen_ping_q, seen_ping_d;
    logic [63:0] pongs_sent_q, pongs_sent_d;
    logic [63:0] pings_dropped_q, pings_dropped_d;
    logic [63:0] tx_timeouts_q, tx_timeouts_d;
    logic [63:0] out_of_order_q, out_of_order_d;

    logic ping;
    assign ping = rx_ping_valid_i & enable_i;

    always_comb begin
        state_d         = state_q;
        count_d         = count_q;
        trigger_d       = 1'b0;
        done_d          = 1'b0;
        ping_id_d       = ping_id_q;
        psize_d         = psize_q;
        expected_id_d   = expected_id_q;
        seen_ping_d     = seen_ping_q;
        pongs_sent_d    = pongs_sent_q;
        pings_dropped_d = pings_dropped_q;
        tx_timeouts_d   = tx_timeouts_q;
        out_of_order_d  = out_of_order_q;

        // Any busy cycle, including the one in which a response ends, drops the ping.
        if (ping && (state_q != StIdle)) begin
            pings_dropped_d = pings_dropped_q + 64'd1;
        end

        case (state_q)
            StIdle: begin
                if (ping) begin
                    ping_id_d     = rx_ping_id_i;
                    psize_d       = (rx_psize_i > MIN_PSIZE) ? rx_psize_i : MIN_PSIZE;
                    count_d       = 32'd1;
                    state_d       = StHoldoff;
                    expected_id_d = rx_ping_id_i + 64'd1;
                    seen_ping_d   = 1'b1;
                    if (seen_ping_q && (rx_ping_id_i != expected_id_q)) begin
                        out_of_order_d = out_of_order_q + 64'd1;
                    end
                end
            end
            StHoldoff: begin
                if (count_q >= holdoff_time_i) begin
                    trigger_d = 1'b1;
                    count_d   = 32'd1;
                    state_d   = StWaitTx;
                end else begin
                    count_d = count_q + 32'd1;
                end
            end
            StWaitTx: begin
                if (tx_begin_i) begin
                    pongs_sent_d = pongs_sent_q + 64'd1;
                    done_d       = 1'b1;
                    state_d      = StIdle;
                end else if ((tx_timeout_i != 32'd0) && (count_q >= tx_timeout_i)) begin
                    tx_timeouts_d = tx_timeouts_q + 64'd1;
                    done_d        = 1'b1;
                    state_d       = StIdle;
                end else begin
                    count_d = count_q + 32'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q         <= StIdle;
            count_q         <= 32'd1;
            trigger_q       <= 1'b0;
            done_q          <= 1'b0;
            ping_id_q       <= 64'd0;
            psize_q         <= MIN_PSIZE;
            expected_id_q   <= 64'd0;
            seen_ping_q     <= 1'b0;
            pongs_sent_q    <= 64'd0;
            pings_dropped_q <= 64'd0;
            tx_timeouts_q   <= 64'd0;
            out_of_order_q  <= 64'd0;
        end else begin
            state_q         <= state_d;
            count_q         <= count_d;
            trigger_q       <= trigger_d;
            done_q          <= done_d;
            ping_id_q       <= ping_id_d;
            psize_q         <= psize_d;
            expected_id_q   <= expected_id_d;
            seen_ping_q     <= seen_ping_d;
            pongs_sent_q    <= pongs_sent_d;
            pings_dropped_q <= pings_dropped_d;
            tx_timeouts_q   <= tx_timeouts_d;
            out_of_order_q  <= out_of_order_d;
        end
    end

    assign tx_trigger_o    = trigger_q;
    assign done_o          = done_q;
    assign tx_ping_id_o    = ping_id_q;
    assign tx_psize_o      = psize_q;
    assign pongs_sent_o    = pongs_sent_q;
    assign pings_dropped_o = pings_dropped_q;
    assign tx_timeouts_o   = tx_timeouts_q;
    assign out_of_order_o  = out_of_order_q;

endmodule
